// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the CPU run controller.
// Controller state encoding, interface widths and default sizing live here
// so the controller and its cycle counter agree on them.
package cpu_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    // Default number of program/data slots loaded per sequence
    localparam int MEM_DEPTH_DEF  = 16;
    // Default run-cycle limit before a run is declared timed out
    localparam int MAX_CYCLES_DEF = 64;

    // Interface widths
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int PROG_W  = 8;
    localparam int COUNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        if (value == '1) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_run_cycle_ctr.sv
// cpu_run_cycle_ctr: counts enabled CPU cycles of one run.
// The count saturates at 255; limit_hit flags the enabled cycle that
// brings the count up to MAX_CYCLES.
module cpu_run_cycle_ctr
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               limit_hit
);

    // Enabled-cycle counter, cleared at the start of every sequence
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

    // Limit is reached when this enabled cycle is the MAX_CYCLES-th one
    always_comb begin
        limit_hit = enable && (count == COUNT_W'(MAX_CYCLES - 1));
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads a program/data image into the CPU store from a host
// valid/ready stream, then runs the CPU until it halts or a cycle limit
// expires.
// Build option: define CPU_RUN_SINGLE_STEP_EN to add the 'step' input,
// which gates the CPU clock enable (and the cycle count) in RUN.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef CPU_RUN_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [PROG_W-1:0]  host_prog,
    input  logic [DATA_W-1:0]  host_data,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PROG_W-1:0]  mem_prog,
    output logic [DATA_W-1:0]  mem_data,
    output logic               cpu_clear,
    output logic               cpu_run,
    input  logic               cpu_halt,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [COUNT_W-1:0] cycle_count
);

    run_state_t          state;
    run_state_t          state_nxt;
    logic [ADDR_W-1:0]   load_idx;
    logic                start_ok;
    logic                xfer;
    logic                last_beat;
    logic                step_ok;
    logic                limit_hit;

    // Start is only honoured while the controller is at rest
    always_comb begin
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
        xfer      = host_valid && host_ready;
        last_beat = xfer && (load_idx == ADDR_W'(MEM_DEPTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; halt takes priority over the cycle limit
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_beat) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_halt || limit_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs, including the optional single-step gate
    always_comb begin
`ifdef CPU_RUN_SINGLE_STEP_EN
        step_ok = step;
`else
        step_ok = 1'b1;
`endif
        host_ready = (state == ST_LOAD);
        cpu_run    = (state == ST_RUN) && step_ok;
        busy       = (state == ST_LOAD) || (state == ST_RUN);
        done       = (state == ST_DONE);
    end

    // Load datapath: each accepted beat becomes a one-cycle write next cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_prog  <= '0;
            mem_data  <= '0;
            cpu_clear <= 1'b0;
        end else begin
            cpu_clear <= start_ok;
            mem_we    <= xfer;
            if (start_ok) begin
                load_idx <= '0;
            end else if (xfer) begin
                load_idx <= load_idx + 1'b1;
            end
            if (xfer) begin
                mem_addr <= load_idx;
                mem_prog <= host_prog;
                mem_data <= host_data;
            end
        end
    end

    // Timeout flag: set only when the limit ends a run without a halt
    always_ff @(posedge clk) begin
        if (!reset) begin
            timed_out <= 1'b0;
        end else if (start_ok) begin
            timed_out <= 1'b0;
        end else if ((state == ST_RUN) && limit_hit && !cpu_halt) begin
            timed_out <= 1'b1;
        end
    end

    cpu_run_cycle_ctr #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .enable    (cpu_run),
        .count     (cycle_count),
        .limit_hit (limit_hit)
    );

    // Protocol invariants of the controller outputs
    a_clear_single: assert property (@(posedge clk) disable iff (!reset)
        cpu_clear |=> !cpu_clear);
    a_run_in_busy: assert property (@(posedge clk) disable iff (!reset)
        cpu_run |-> busy);
    a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset)
        !(busy && done));

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl.
// Define CPU_RUN_SINGLE_STEP_EN to also exercise the single-step option.
module tb_cpu_run_ctrl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       start      = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_prog  = 8'h00;
    logic [3:0] host_data  = 4'h0;
    logic       cpu_halt   = 1'b0;
`ifdef CPU_RUN_SINGLE_STEP_EN
    logic       step       = 1'b1;
`endif
    logic       host_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_prog;
    logic [3:0] mem_data;
    logic       cpu_clear;
    logic       cpu_run;
    logic       busy;
    logic       done;
    logic       timed_out;
    logic [7:0] cycle_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Write / pulse log sampled on the falling edge
    int unsigned wr_cnt  = 0;
    int unsigned clr_cnt = 0;
    int unsigned run_cnt = 0;
    logic [3:0]  wr_addr [0:255];
    logic [7:0]  wr_prog [0:255];
    logic [3:0]  wr_data [0:255];

    cpu_run_ctrl #(
        .MEM_DEPTH  (16),
        .MAX_CYCLES (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef CPU_RUN_SINGLE_STEP_EN
        .step        (step),
`endif
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_prog   (host_prog),
        .host_data   (host_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_prog    (mem_prog),
        .mem_data    (mem_data),
        .cpu_clear   (cpu_clear),
        .cpu_run     (cpu_run),
        .cpu_halt    (cpu_halt),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_prog[wr_cnt] = mem_prog;
                wr_data[wr_cnt] = mem_data;
            end
            wr_cnt++;
        end
        if (cpu_clear) clr_cnt++;
        if (cpu_run)   run_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted start: returns in the first LOAD cycle
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 16 back-to-back beats; returns in the first RUN cycle
    task automatic load_all(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            host_valid = 1'b1;
            host_prog  = 8'(base + 8'(i));
            host_data  = 4'(i);
            tick();
        end
        host_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({host_ready, mem_we, cpu_clear, cpu_run, busy, done, timed_out} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {host_ready, mem_we, cpu_clear, cpu_run, busy, done, timed_out});
        end
        n_checks++;
        if ({mem_addr, mem_prog, mem_data, cycle_count} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 000000",
                     {mem_addr, mem_prog, mem_data, cycle_count});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back_halt();
        int unsigned wr_base  = wr_cnt;
        int unsigned clr_base = clr_cnt;
        int unsigned run_base = run_cnt;
        do_start();
        n_checks++;
        if (cpu_clear !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_clear: cpu_clear=%b busy=%b expected 1 1", cpu_clear, busy);
        end
        for (int i = 0; i < 16; i++) begin
            host_valid = 1'b1;
            host_prog  = 8'(8'h30 + 8'(i));
            host_data  = 4'(i);
            n_checks++;
            if (host_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready beat %0d: got %b expected 1", i, host_ready);
            end
            tick();
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_prog !== 8'(8'h30 + 8'(i)) || mem_data !== 4'(i)) begin
                n_fail++;
                $display("FAIL b2b_write beat %0d: we=%b addr=%0d prog=%h data=%h expected 1 %0d %h %h",
                         i, mem_we, mem_addr, mem_prog, mem_data, i, 8'h30 + i, i);
            end
        end
        // Extra beat presented in RUN must be refused
        host_valid = 1'b1;
        host_prog  = 8'hFF;
        host_data  = 4'hF;
        n_checks++;
        if (host_ready !== 1'b0 || cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_run_entry: host_ready=%b cpu_run=%b expected 0 1", host_ready, cpu_run);
        end
        tick();
        host_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_17th: mem_we=%b expected 0", mem_we);
        end
        repeat (8) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cpu_run !== 1'b0 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_flags: done=%b cpu_run=%b timed_out=%b expected 1 0 0", done, cpu_run, timed_out);
        end
        n_checks++;
        if (cycle_count !== 8'd10) begin
            n_fail++;
            $display("FAIL halt_count: got %0d expected 10", cycle_count);
        end
        n_checks++;
        if (run_cnt - run_base != 10 || clr_cnt - clr_base != 1 || wr_cnt - wr_base != 16) begin
            n_fail++;
            $display("FAIL b2b_totals: runs=%0d clears=%0d writes=%0d expected 10 1 16",
                     run_cnt - run_base, clr_cnt - clr_base, wr_cnt - wr_base);
        end
    endtask

    task automatic test_done_hold();
        int unsigned wr_base = wr_cnt;
        host_valid = 1'b1;
        repeat (3) tick();
        host_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cycle_count !== 8'd10 || timed_out !== 1'b0 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: done=%b count=%0d timed_out=%b ready=%b expected 1 10 0 0",
                     done, cycle_count, timed_out, host_ready);
        end
        n_checks++;
        if (wr_cnt != wr_base) begin
            n_fail++;
            $display("FAIL done_no_write: writes=%0d expected 0", wr_cnt - wr_base);
        end
    endtask

    task automatic test_gapped_timeout();
        int unsigned wr_base  = wr_cnt;
        int unsigned clr_base = clr_cnt;
        int unsigned run_base = run_cnt;
        int unsigned n = 0;
        do_start();
        for (int i = 0; i < 16; i++) begin
            host_valid = 1'b1;
            host_prog  = 8'(8'h80 + 8'(i));
            host_data  = 4'(15 - i);
            tick();
            if (i < 15) begin
                host_valid = 1'b0;
                host_prog  = 8'hEE;
                host_data  = 4'hE;
                if (i == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        host_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || host_ready !== 1'b0 || cpu_run !== 1'b1 || mem_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL gap_run_entry: busy=%b ready=%b cpu_run=%b addr=%0d expected 1 0 1 15",
                     busy, host_ready, cpu_run, mem_addr);
        end
        n_checks++;
        if (clr_cnt - clr_base != 1) begin
            n_fail++;
            $display("FAIL gap_start_ignored: clears=%0d expected 1", clr_cnt - clr_base);
        end
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles expected 64", n);
        end
        n_checks++;
        if (timed_out !== 1'b1 || cycle_count !== 8'd64 || run_cnt - run_base != 64) begin
            n_fail++;
            $display("FAIL timeout_flags: timed_out=%b count=%0d runs=%0d expected 1 64 64",
                     timed_out, cycle_count, run_cnt - run_base);
        end
        n_checks++;
        if (wr_cnt - wr_base != 16) begin
            n_fail++;
            $display("FAIL gap_writes: got %0d expected 16", wr_cnt - wr_base);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (wr_addr[wr_base + k] !== 4'(k) || wr_prog[wr_base + k] !== 8'(8'h80 + 8'(k)) ||
                wr_data[wr_base + k] !== 4'(15 - k)) begin
                n_fail++;
                $display("FAIL gap_beat %0d: addr=%0d prog=%h data=%h expected %0d %h %h",
                         k, wr_addr[wr_base + k], wr_prog[wr_base + k], wr_data[wr_base + k],
                         k, 8'h80 + k, 15 - k);
            end
        end
    endtask

    task automatic test_halt_at_limit();
        do_start();
        n_checks++;
        if (timed_out !== 1'b0 || cycle_count !== 8'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: timed_out=%b count=%0d done=%b expected 0 0 0",
                     timed_out, cycle_count, done);
        end
        load_all(8'h10);
        repeat (63) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        n_checks++;
        if (done !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 8'd64) begin
            n_fail++;
            $display("FAIL halt_at_limit: done=%b timed_out=%b count=%0d expected 1 0 64",
                     done, timed_out, cycle_count);
        end
    endtask

    task automatic test_reset_mid_load();
        int unsigned wr_base = wr_cnt;
        do_start();
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_prog  = 8'(8'hA0 + 8'(i));
            host_data  = 4'(i);
            tick();
        end
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({host_ready, mem_we, cpu_clear, cpu_run, busy, done, timed_out} !== 7'b0 ||
            {mem_addr, mem_prog, mem_data, cycle_count} !== 24'h0) begin
            n_fail++;
            $display("FAIL midload_reset: flags=%b data=%h expected 0000000 000000",
                     {host_ready, mem_we, cpu_clear, cpu_run, busy, done, timed_out},
                     {mem_addr, mem_prog, mem_data, cycle_count});
        end
        reset = 1'b1;
        repeat (3) tick();
        host_valid = 1'b0;
        n_checks++;
        if (wr_cnt - wr_base != 5 || busy !== 1'b0 || host_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_after: writes=%0d busy=%b ready=%b we=%b expected 5 0 0 0",
                     wr_cnt - wr_base, busy, host_ready, mem_we);
        end
    endtask

`ifdef CPU_RUN_SINGLE_STEP_EN
    task automatic test_single_step();
        int unsigned run_base;
        logic [6:0]  pat = 7'b0101010;
        do_start();
        step = 1'b0;
        load_all(8'h50);
        run_base = run_cnt;
        for (int k = 0; k < 7; k++) begin
            step     = pat[k];
            cpu_halt = (k == 6);
            #1;
            n_checks++;
            if (cpu_run !== pat[k]) begin
                n_fail++;
                $display("FAIL step_gate %0d: cpu_run=%b expected %b", k, cpu_run, pat[k]);
            end
            tick();
        end
        cpu_halt = 1'b0;
        step     = 1'b1;
        n_checks++;
        if (done !== 1'b1 || cycle_count !== 8'd3 || run_cnt - run_base != 3) begin
            n_fail++;
            $display("FAIL step_count: done=%b count=%0d runs=%0d expected 1 3 3",
                     done, cycle_count, run_cnt - run_base);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back_halt();
        test_done_hold();
        test_gapped_timeout();
        test_halt_at_limit();
        test_reset_mid_load();
`ifdef CPU_RUN_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
